// File: rtl/im_loader.sv
// Framed byte-stream loader for instruction memory: LEN_HI, LEN_LO, 4N data bytes, XOR checksum.
// Writes big-endian 32-bit words and holds the CPU in reset until a frame checks out.
module im_loader #(
  parameter int ADDR_WIDTH    = 8,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int IW = ADDR_WIDTH + 1;
  localparam logic [16:0] CAP = 17'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR} state_t;

  state_t          state_q, state_d;
  logic [7:0]      len_hi_q, len_hi_d;
  logic [15:0]     n_q, n_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [23:0]     word_q, word_d;
  logic [7:0]      csum_q, csum_d;
  logic            im_we_q, im_we_d;
  logic [31:0]     im_addr_q, im_addr_d;
  logic [31:0]     im_wdata_q, im_wdata_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            hold_q, hold_d;
  logic            accept;
  logic [15:0]     n_new;

  assign in_ready = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                    (state_q == DATA)   || (state_q == CSUM);
  assign accept   = in_valid && in_ready;
  assign n_new    = {len_hi_q, in_data};

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    n_d        = n_q;
    idx_d      = idx_q;
    bcnt_d     = bcnt_q;
    word_d     = word_q;
    csum_d     = csum_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    hold_d     = hold_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = LEN_HI;
          done_d  = 1'b0;
          error_d = 1'b0;
          csum_d  = 8'h00;
          idx_d   = '0;
          bcnt_d  = 2'd0;
          busy_d  = 1'b1;
          hold_d  = 1'b1;
        end
      end
      LEN_HI: if (accept) begin
        len_hi_d = in_data;
        state_d  = LEN_LO;
      end
      LEN_LO: if (accept) begin
        n_d = n_new;
        if ({1'b0, n_new} > CAP) begin
          state_d = ERROR;
          error_d = 1'b1;
          busy_d  = 1'b0;
          hold_d  = 1'b1;
        end else if (n_new == 16'd0) begin
          state_d = CSUM;
        end else begin
          state_d = DATA;
        end
      end
      DATA: if (accept) begin
        csum_d = csum_q ^ in_data;
        word_d = {word_q[15:0], in_data};
        bcnt_d = bcnt_q + 2'd1;
        // Write is registered, so the pulse lands the cycle after the 4th byte.
        if (bcnt_q == 2'd3) begin
          im_we_d    = 1'b1;
          im_addr_d  = 32'({idx_q[ADDR_WIDTH-1:0], 2'b00});
          im_wdata_d = {word_q, in_data};
          idx_d      = idx_q + 1'b1;
          if (17'(idx_q) + 17'd1 == {1'b0, n_q}) state_d = CSUM;
        end
      end
      CSUM: if (accept) begin
        busy_d = 1'b0;
        if (in_data == csum_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          hold_d  = 1'b0;
        end else begin
          state_d = ERROR;
          error_d = 1'b1;
          hold_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      len_hi_q   <= 8'h00;
      n_q        <= 16'h0000;
      idx_q      <= '0;
      bcnt_q     <= 2'd0;
      word_q     <= 24'h0;
      csum_q     <= 8'h00;
      im_we_q    <= 1'b0;
      im_addr_q  <= 32'h0;
      im_wdata_q <= 32'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      hold_q     <= HOLD_AT_RESET;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      bcnt_q     <= bcnt_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      hold_q     <= hold_d;
    end
  end

  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign cpu_hold = hold_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_im_loader.sv
// Randomized bench for im_loader: frames built from byte lists, expected writes and
// final status derived from the frame rules, writes scoreboarded as they appear.
module tb_im_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, im_we, cpu_hold, busy, done, error;
  logic [31:0] im_addr, im_wdata;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [7:0]  dbytes[$];
  logic [31:0] last_addr = 32'h0;
  int          nwrites = 0;

  im_loader #(.ADDR_WIDTH(8), .HOLD_AT_RESET(1'b1)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Write scoreboard
  always @(negedge clock) begin
    if (im_we) begin
      nwrites++;
      last_addr = im_addr;
      if (exp_addr.size() == 0) begin
        chk("spurious_we", 32'd1, 32'd0);
      end else begin
        chk("we_addr", im_addr, exp_addr.pop_front());
        chk("we_data", im_wdata, exp_data.pop_front());
      end
    end
  end

  task automatic pulse_start(input logic [7:0] b0);
    @(negedge clock);
    start    = 1'b1;
    in_valid = 1'b1;   // offered in IDLE, must not be consumed
    in_data  = b0;
  endtask

  task automatic send_bytes(input logic [7:0] q[$], input int gap, input bit inj);
    int i = 0;
    int guard = 0;
    while (i < q.size()) begin
      @(negedge clock);
      in_valid = ($urandom_range(99) >= gap);
      in_data  = q[i];
      start    = (inj && i == 5) ? 1'b1 : 1'b0;
      if (in_valid && in_ready) i++;
      guard++;
      if (guard > 20000) begin
        chk("send_timeout", 32'(i), 32'(q.size()));
        break;
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Builds the frame from dbytes, queues the expected writes, sends, checks the outcome.
  task automatic run_frame(input int n, input bit bad, input int gap, input bit inj, input string tag);
    logic [7:0]  q[$];
    logic [7:0]  x = 8'h00;
    logic [31:0] w;
    bit ok;
    q.push_back(8'(n >> 8));
    q.push_back(8'(n));
    ok = !bad && n <= 256;
    if (n <= 256) begin
      for (int k = 0; k < n; k++) begin
        w = {dbytes[4*k], dbytes[4*k+1], dbytes[4*k+2], dbytes[4*k+3]};
        exp_addr.push_back(32'(k * 4));
        exp_data.push_back(w);
        for (int b = 0; b < 4; b++) begin
          q.push_back(dbytes[4*k+b]);
          x ^= dbytes[4*k+b];
        end
      end
      q.push_back(bad ? (x ^ 8'h5A) : x);
    end
    nwrites = 0;
    pulse_start(q[0]);
    send_bytes(q, gap, inj);
    repeat (3) @(negedge clock);
    chk({tag, "_done"},     {31'd0, done},     {31'd0, ok});
    chk({tag, "_error"},    {31'd0, error},    {31'd0, !ok});
    chk({tag, "_hold"},     {31'd0, cpu_hold}, {31'd0, !ok});
    chk({tag, "_busy"},     {31'd0, busy},     32'd0);
    chk({tag, "_ready"},    {31'd0, in_ready}, 32'd0);
    chk({tag, "_nwrites"},  32'(nwrites),      32'(n <= 256 ? n : 0));
    chk({tag, "_leftover"}, 32'(exp_addr.size()), 32'd0);
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic load_frame1();
    logic [7:0] f1[$] = '{8'h00, 8'h22, 8'h18, 8'h20, 8'h00, 8'hE4, 8'h30, 8'h22};
    dbytes = f1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_we"},    {31'd0, im_we},    32'd0);
    chk({tag, "_addr"},  im_addr,           32'd0);
    chk({tag, "_wdata"}, im_wdata,          32'd0);
    chk({tag, "_busy"},  {31'd0, busy},     32'd0);
    chk({tag, "_done"},  {31'd0, done},     32'd0);
    chk({tag, "_error"}, {31'd0, error},    32'd0);
    chk({tag, "_hold"},  {31'd0, cpu_hold}, 32'd1);
  endtask

  initial begin
    logic [7:0] part[$];
    int n;
    repeat (2) @(negedge clock);
    check_reset_vals("rst");
    reset = 1'b1;
    @(negedge clock);

    load_frame1();
    run_frame(2, 1'b0, 0, 1'b0, "f1");
    chk("f1_last_addr", last_addr, 32'h4);

    load_frame1();
    run_frame(2, 1'b1, 0, 1'b0, "f1bad");
    chk("hold_addr",  im_addr,  32'h4);
    chk("hold_wdata", im_wdata, 32'h00E43022);

    dbytes.delete();
    run_frame(0, 1'b0, 0, 1'b0, "empty");

    run_frame(257, 1'b0, 0, 1'b0, "toolong");
    run_frame(257 + $urandom_range(0, 4000), 1'b0, 20, 1'b0, "toolong_rnd");

    dbytes.delete();
    for (int i = 0; i < 1024; i++) dbytes.push_back(8'($urandom));
    run_frame(256, 1'b0, 0, 1'b0, "full");
    chk("full_last_addr", last_addr, 32'h3FC);

    load_frame1();
    run_frame(2, 1'b0, 50, 1'b1, "f1gap");

    // Reset in the middle of a frame after two data bytes
    part = '{8'h00, 8'h02, 8'h00, 8'h22};
    nwrites = 0;
    pulse_start(part[0]);
    send_bytes(part, 0, 1'b0);
    reset = 1'b0;
    #1;
    check_reset_vals("midrst");
    chk("midrst_nwrites", 32'(nwrites), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    load_frame1();
    run_frame(2, 1'b0, 30, 1'b0, "after_rst");

    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 12);
      dbytes.delete();
      for (int i = 0; i < 4 * n; i++) dbytes.push_back(8'($urandom));
      run_frame(n, 1'($urandom_range(1)), 40, 1'($urandom_range(1)), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
